// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: redirect input, instruction memory port and decode-side port.
// The master modport is the fetch unit; the slave modport is the surrounding core/memory.
interface instr_fetch_if;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        instr_ready;

   modport master (
      input  redirect, redirect_addr, imem_ack, imem_rdata, instr_ready,
      output imem_req, imem_addr, instr_valid, instr_data, instr_pc
   );

   modport slave (
      output redirect, redirect_addr, imem_ack, imem_rdata, instr_ready,
      input  imem_req, imem_addr, instr_valid, instr_data, instr_pc
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory requests feeding a DEPTH-entry
// {pc, instr} buffer, with redirect flush and discard of an in-flight response.
module instr_fetch #(
   parameter int          DEPTH      = 4,
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst,
   instr_fetch_if.master bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
   localparam logic [31:0] RESET_ALIGNED = {RESET_ADDR[31:2], 2'b00};

   typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

   state_t           state_q, state_d;
   logic [31:0]      fetch_q, fetch_d;
   logic [31:0]      addr_q, addr_d;
   logic [PTR_W-1:0] wr_q, rd_q;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      pc_mem    [DEPTH];
   logic [31:0]      instr_mem [DEPTH];
   logic             push, pop, flush, valid;
   logic             unused_addr_lsbs;

   assign unused_addr_lsbs = ^bus.redirect_addr[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         fetch_q <= RESET_ALIGNED;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         fetch_q <= fetch_d;
         addr_q  <= addr_d;
      end
   end

   // Occupancy below DEPTH at issue reserves the slot the response will land in.
   always_comb begin
      state_d = state_q;
      fetch_d = fetch_q;
      addr_d  = addr_q;
      push    = 1'b0;
      flush   = bus.redirect;
      case (state_q)
         IDLE: begin
            if (!bus.redirect && (cnt_q < FULL)) begin
               state_d = WAIT;
               addr_d  = fetch_q;
            end
         end
         WAIT: begin
            if (bus.redirect) begin
               state_d = bus.imem_ack ? IDLE : DISCARD;
            end else if (bus.imem_ack) begin
               push    = 1'b1;
               fetch_d = fetch_q + 32'd4;
               state_d = IDLE;
            end
         end
         DISCARD: begin
            if (bus.imem_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (bus.redirect) fetch_d = {bus.redirect_addr[31:2], 2'b00};
   end

   assign valid = (cnt_q != '0);
   assign pop   = valid && bus.instr_ready && !flush;

   always_comb begin
      bus.imem_req    = (state_q != IDLE);
      bus.imem_addr   = addr_q;
      bus.instr_valid = valid;
      bus.instr_data  = valid ? instr_mem[rd_q] : '0;
      bus.instr_pc    = valid ? pc_mem[rd_q]    : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + PTR_W'(1);
         if (pop)  rd_q <= rd_q + PTR_W'(1);
         if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
         else if (!push && pop) cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_q]    <= addr_q;
         instr_mem[wr_q] <= bus.imem_rdata;
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory model, queue scoreboard of expected {pc, instr},
// redirect vector table, and hand sequences for back-pressure, discard and reset.
module tb_instr_fetch;
   localparam logic [31:0] RST_ADDR = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } ent_t;

   typedef struct {
      logic [31:0] tgt;
      int          lat;
      int          n;
      logic [31:0] first;
      logic [31:0] last;
   } vec_t;

   logic        clk;
   logic        rst;
   int          n_vec  = 0;
   int          n_miss = 0;
   int          mem_lat = 0;
   bit          stray_ack = 0;
   bit          disc = 0;
   logic [31:0] exp_fetch = RST_ADDR;
   ent_t        exp_q[$];
   logic [31:0] popped_pc[$];
   vec_t        vecs[5];

   instr_fetch_if bus();

   instr_fetch #(.DEPTH(4), .RESET_ADDR(RST_ADDR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Memory: ack after mem_lat extra cycles of a held request
   initial begin : memory
      int cnt;
      cnt = 0;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.imem_ack   = 1'b0;
         bus.imem_rdata = '0;
         if (stray_ack) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = 32'hDEAD_BEEF;
            stray_ack      = 1'b0;
         end else if (bus.imem_req && !rst) begin
            if (cnt >= mem_lat) begin
               bus.imem_ack   = 1'b1;
               bus.imem_rdata = mem_data(bus.imem_addr);
               cnt            = 0;
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Scoreboard and protocol monitor
   initial begin : monitor
      logic        p_req, p_ack, p_ok;
      logic [31:0] p_addr;
      ent_t        e;
      p_ok = 1'b0; p_req = 1'b0; p_ack = 1'b0; p_addr = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            disc      = 1'b0;
            exp_fetch = RST_ADDR;
            p_ok      = 1'b0;
         end else begin
            if (p_ok && p_req && !p_ack) begin
               check("hold_req", {31'b0, bus.imem_req}, 32'd1);
               check("hold_addr", bus.imem_addr, p_addr);
            end
            if (p_ok && p_req && p_ack) check("idle_after_ack", {31'b0, bus.imem_req}, 32'd0);
            check("valid", {31'b0, bus.instr_valid}, {31'b0, exp_q.size() != 0});
            if (bus.instr_valid && bus.instr_ready && exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("pc", bus.instr_pc, e.pc);
               check("data", bus.instr_data, e.data);
               popped_pc.push_back(bus.instr_pc);
            end
            if (bus.redirect) begin
               exp_q.delete();
               disc      = bus.imem_req && !bus.imem_ack;
               exp_fetch = {bus.redirect_addr[31:2], 2'b00};
            end else if (bus.imem_req && bus.imem_ack) begin
               if (!disc) begin
                  check("fetch_addr", bus.imem_addr, exp_fetch);
                  e.pc   = exp_fetch;
                  e.data = mem_data(exp_fetch);
                  exp_q.push_back(e);
                  exp_fetch = exp_fetch + 32'd4;
               end
               disc = 1'b0;
            end
            p_req  = bus.imem_req;
            p_ack  = bus.imem_ack;
            p_addr = bus.imem_addr;
            p_ok   = 1'b1;
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   initial begin : test
      logic [31:0] old_addr;
      bit          found;
      logic        pr;
      int          rises;

      vecs[0] = '{32'h0000_0102, 0, 3, 32'h0000_0100, 32'h0000_0108};
      vecs[1] = '{32'hFFFF_FFFC, 1, 2, 32'hFFFF_FFFC, 32'h0000_0000};
      vecs[2] = '{32'h1000_0007, 2, 4, 32'h1000_0004, 32'h1000_0010};
      vecs[3] = '{32'h0000_0040, 0, 5, 32'h0000_0040, 32'h0000_0050};
      vecs[4] = '{32'h8000_0001, 3, 1, 32'h8000_0000, 32'h8000_0000};

      rst = 1'b1;
      bus.redirect = 1'b0;
      bus.redirect_addr = '0;
      bus.instr_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_req",   {31'b0, bus.imem_req},    32'd0);
      check("rst_addr",  bus.imem_addr,            32'd0);
      check("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
      check("rst_data",  bus.instr_data,           32'd0);
      check("rst_pc",    bus.instr_pc,             32'd0);

      // Release: first request on first edge, then one idle cycle between requests
      bus.instr_ready = 1'b1;
      rst = 1'b0;
      popped_pc.delete();
      tick();
      check("first_req",  {31'b0, bus.imem_req}, 32'd1);
      check("first_addr", bus.imem_addr, RST_ADDR);
      tick();
      check("gap_req", {31'b0, bus.imem_req}, 32'd0);
      tick();
      check("second_req",  {31'b0, bus.imem_req}, 32'd1);
      check("second_addr", bus.imem_addr, 32'h4);
      for (int i = 0; i < 40 && popped_pc.size() < 3; i++) tick();
      check("boot_cnt", popped_pc.size() >= 3 ? 32'd1 : 32'd0, 32'd1);
      if (popped_pc.size() >= 3) begin
         check("boot_pc0", popped_pc[0], 32'h0);
         check("boot_pc1", popped_pc[1], 32'h4);
         check("boot_pc2", popped_pc[2], 32'h8);
      end

      // Redirect vector table
      for (int v = 0; v < 5; v++) begin
         mem_lat = vecs[v].lat;
         bus.redirect = 1'b1;
         bus.redirect_addr = vecs[v].tgt;
         tick();
         bus.redirect = 1'b0;
         popped_pc.delete();
         check("vec_flush", {31'b0, bus.instr_valid}, 32'd0);
         for (int i = 0; i < 120 && popped_pc.size() < vecs[v].n; i++) tick();
         check("vec_cnt", popped_pc.size() >= vecs[v].n ? 32'd1 : 32'd0, 32'd1);
         if (popped_pc.size() >= vecs[v].n) begin
            check("vec_first", popped_pc[0], vecs[v].first);
            check("vec_last", popped_pc[vecs[v].n-1], vecs[v].last);
         end
      end

      // Redirect in WAIT, ack arrives three cycles later and is dropped
      bus.instr_ready = 1'b0;
      mem_lat = 3;
      found = 1'b0;
      pr = bus.imem_req;
      for (int i = 0; i < 80 && !found; i++) begin
         tick();
         if (bus.imem_req && !pr && bus.instr_valid) found = 1'b1;
         pr = bus.imem_req;
      end
      check("disc_setup", {31'b0, found}, 32'd1);
      old_addr = bus.imem_addr;
      bus.redirect = 1'b1;
      bus.redirect_addr = 32'h0000_0102;
      tick();
      bus.redirect = 1'b0;
      check("disc_valid", {31'b0, bus.instr_valid}, 32'd0);
      check("disc_req",   {31'b0, bus.imem_req},    32'd1);
      check("disc_addr",  bus.imem_addr,            old_addr);
      for (int i = 0; i < 20 && bus.imem_req; i++) tick();
      for (int i = 0; i < 20 && !bus.imem_req; i++) tick();
      check("disc_next_req",  {31'b0, bus.imem_req}, 32'd1);
      check("disc_next_addr", bus.imem_addr, 32'h0000_0100);

      // Redirect coincident with ack
      bus.instr_ready = 1'b1;
      mem_lat = 2;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (bus.imem_ack && bus.imem_req) found = 1'b1;
      end
      check("coin_setup", {31'b0, found}, 32'd1);
      bus.redirect = 1'b1;
      bus.redirect_addr = 32'h0000_0040;
      tick();
      bus.redirect = 1'b0;
      popped_pc.delete();
      check("coin_idle", {31'b0, bus.imem_req}, 32'd0);
      tick();
      check("coin_req",  {31'b0, bus.imem_req}, 32'd1);
      check("coin_addr", bus.imem_addr, 32'h0000_0040);
      for (int i = 0; i < 40 && popped_pc.size() < 1; i++) tick();
      check("coin_cnt", popped_pc.size() >= 1 ? 32'd1 : 32'd0, 32'd1);
      if (popped_pc.size() >= 1) check("coin_pc", popped_pc[0], 32'h0000_0040);

      // Back-pressure: buffer fills after exactly DEPTH requests
      bus.instr_ready = 1'b0;
      mem_lat = 0;
      bus.redirect = 1'b1;
      bus.redirect_addr = 32'h0000_0200;
      tick();
      bus.redirect = 1'b0;
      rises = 0;
      pr = bus.imem_req;
      repeat (30) begin
         tick();
         if (bus.imem_req && !pr) rises++;
         pr = bus.imem_req;
      end
      check("full_reqs", rises, 32'd4);
      check("full_idle", {31'b0, bus.imem_req}, 32'd0);
      bus.instr_ready = 1'b1;
      tick();
      bus.instr_ready = 1'b0;
      rises = 0;
      pr = bus.imem_req;
      repeat (20) begin
         tick();
         if (bus.imem_req && !pr) rises++;
         pr = bus.imem_req;
      end
      check("one_more_req", rises, 32'd1);

      // Stray ack while IDLE with a full buffer must not push
      stray_ack = 1'b1;
      tick();
      tick();
      tick();
      bus.instr_ready = 1'b1;
      repeat (12) tick();

      // Asynchronous reset in the middle of WAIT
      bus.instr_ready = 1'b0;
      mem_lat = 5;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         if (bus.imem_req && bus.instr_valid) found = 1'b1;
      end
      check("arst_setup", {31'b0, found}, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("arst_req",   {31'b0, bus.imem_req},    32'd0);
      check("arst_valid", {31'b0, bus.instr_valid}, 32'd0);
      check("arst_addr",  bus.imem_addr,            32'd0);
      check("arst_data",  bus.instr_data,           32'd0);
      check("arst_pc",    bus.instr_pc,             32'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      bus.instr_ready = 1'b1;
      mem_lat = 0;
      popped_pc.delete();
      tick();
      check("arst_restart_req",  {31'b0, bus.imem_req}, 32'd1);
      check("arst_restart_addr", bus.imem_addr, RST_ADDR);
      for (int i = 0; i < 20 && popped_pc.size() < 1; i++) tick();
      check("arst_cnt", popped_pc.size() >= 1 ? 32'd1 : 32'd0, 32'd1);
      if (popped_pc.size() >= 1) check("arst_pc0", popped_pc[0], RST_ADDR);

      repeat (4) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the instruction buffer entry count (power of 2, at least 2).
REQ-002 The block SHALL have parameter RESET_ADDR, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 The block SHALL have port redirect, input, 1 bit: a taken branch or jump requests a fetch restart.
REQ-006 The block SHALL have port redirect_addr, input, 32 bits: the restart target.
REQ-007 The block SHALL have port imem_req, output, 1 bit: instruction memory read request.
REQ-008 The block SHALL have port imem_addr, output, 32 bits: the read address, word-aligned.
REQ-009 The block SHALL have port imem_ack, input, 1 bit: read complete, with imem_rdata valid in the same cycle.
REQ-010 The block SHALL have port imem_rdata, input, 32 bits: the instruction word.
REQ-011 The block SHALL have port instr_valid, output, 1 bit: an instruction is available to decode.
REQ-012 The block SHALL have port instr_data, output, 32 bits: the instruction word at the buffer head.
REQ-013 The block SHALL have port instr_pc, output, 32 bits: the address of instr_data.
REQ-014 The block SHALL have port instr_ready, input, 1 bit: decode accepts the head entry.

Function
REQ-015 The block SHALL keep a 32-bit fetch address, a DEPTH-entry FIFO of {pc, instr} pairs, and an FSM with states IDLE, WAIT and DISCARD.
REQ-016 IDLE -> WAIT SHALL occur when no redirect is present and the FIFO occupancy is below DEPTH; on that edge imem_req is driven to 1 and imem_addr to the fetch address.
REQ-017 In WAIT, imem_req and imem_addr SHALL be held stable until imem_ack; at most one request is outstanding at any time.
REQ-018 WAIT with imem_ack and no redirect SHALL push {imem_addr, imem_rdata}, add 4 to the fetch address modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000), and move to IDLE.
REQ-019 The FIFO slot SHALL be reserved at issue, so a push never finds the FIFO full.
REQ-020 The block SHALL issue back-to-back requests with one IDLE cycle between an ack and the next request.
REQ-021 instr_valid SHALL be high exactly when the FIFO is non-empty, with instr_data and instr_pc driven from the head entry.
REQ-022 Pop SHALL occur on instr_valid and instr_ready; a push and a pop in the same cycle leave occupancy unchanged.
REQ-023 Latency SHALL be: data acked in cycle N is presented with instr_valid high in cycle N+1.
REQ-024 redirect in any state SHALL empty the FIFO on that edge (instr_valid 0 in the next cycle) and load the fetch address with {redirect_addr[31:2], 2'b00}.
REQ-025 redirect in WAIT without imem_ack SHALL move the FSM to DISCARD, keeping imem_req and the old imem_addr held.
REQ-026 In DISCARD, imem_ack SHALL drop the returned data without pushing it and move the FSM to IDLE; a further redirect in DISCARD only updates the fetch address.
REQ-027 redirect and imem_ack in the same WAIT cycle SHALL drop the ack data, move the FSM to IDLE, and issue the next request from the redirect target.
REQ-028 redirect SHALL take priority over a same-cycle pop and push.
REQ-029 An imem_ack received in IDLE SHALL be ignored.

Reset
REQ-030 While rst is high, the block SHALL hold imem_req 0, imem_addr 0, instr_valid 0, instr_data 0, instr_pc 0, FIFO empty, FSM in IDLE, and fetch address RESET_ADDR, asynchronously and independent of clk.
REQ-031 Reset asserted during WAIT SHALL abandon the outstanding request without waiting for imem_ack.
REQ-032 The first imem_req after reset SHALL rise on the first clk edge after rst deasserts, with imem_addr equal to RESET_ADDR.

Verification
REQ-033 Reset release with zero-wait memory (ack in the cycle after req) and instr_ready=1 -> instr_pc sequence 0x0, 0x4, 0x8, each paired with the matching rdata.
REQ-034 instr_ready=0 with DEPTH=4 -> exactly 4 requests issued, then imem_req stays 0; raising ready for 1 cycle -> exactly one further request.
REQ-035 Redirect to 0x0000_0102 while in WAIT, with ack 3 cycles later -> that ack is not pushed, the next imem_addr is 0x0000_0100, and the FIFO is empty on the cycle after the redirect.
REQ-036 Redirect to 0x0000_0040 in the same cycle as an ack -> the ack data is never seen on the instr_* ports, and the next request is at 0x40.
REQ-037 Redirect to 0xFFFF_FFFC -> instr_pc values 0xFFFF_FFFC then 0x0000_0000.
REQ-038 rst pulsed mid-WAIT between clock edges -> imem_req and instr_valid go to 0 immediately, and the restart is at RESET_ADDR.
